// File: rtl/fm_pool_drain.sv
// Drains output feature maps through a 2x2 stride-2 max-pool onto a valid/ready stream.
// Optional ReLU on the pooled value when CNN_POOL_RELU_EN is defined.
module fm_pool_drain #(
    parameter int M_p      = 4,
    parameter int R_p      = 16,
    parameter int C_p      = 16,
    parameter int DATA_W_p = 16,
    localparam int MW = (M_p > 1) ? $clog2(M_p) : 1,
    localparam int RW = $clog2(R_p),
    localparam int CW = $clog2(C_p)
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                start_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                rd_en_o,
    output logic [MW-1:0]       rd_map_o,
    output logic [RW-1:0]       rd_row_o,
    output logic [CW-1:0]       rd_col_o,
    input  logic [DATA_W_p-1:0] rd_data_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [DATA_W_p-1:0] out_data_o,
    output logic [MW-1:0]       out_map_o,
    output logic                out_last_o
);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_FLUSH, S_EMIT, S_DONE} state_t;

    state_t                      state_q, state_d;
    logic [1:0]                  ph_q, ph_d;
    logic [MW-1:0]               map_q, map_d;
    logic [RW-1:0]               wr_q, wr_d;
    logic [CW-1:0]               wc_q, wc_d;
    logic signed [DATA_W_p-1:0]  max_q, max_d;
    logic                        rd_en_q, rd_en_d;
    logic [MW-1:0]               rd_map_q, rd_map_d;
    logic [RW-1:0]               rd_row_q, rd_row_d;
    logic [CW-1:0]               rd_col_q, rd_col_d;
    logic                        out_valid_q, out_valid_d;
    logic [DATA_W_p-1:0]         out_data_q, out_data_d;
    logic [MW-1:0]               out_map_q, out_map_d;
    logic                        out_last_q, out_last_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;

    logic signed [DATA_W_p-1:0]  rd_data_s, ret_max, pooled;
    logic                        wc_end, wr_end, map_end;
    logic [1:0]                  ph_nx;
    logic [CW-1:0]               nwc;
    logic [RW-1:0]               nwr;
    logic [MW-1:0]               nmap;

    assign rd_data_s = rd_data_i;
    assign wc_end    = (wc_q == CW'(C_p/2 - 1));
    assign wr_end    = (wr_q == RW'(R_p/2 - 1));
    assign map_end   = (map_q == MW'(M_p - 1));
    assign ph_nx     = ph_q + 2'd1;
    assign nwc       = wc_end ? '0 : wc_q + CW'(1);
    assign nwr       = wc_end ? (wr_end ? '0 : wr_q + RW'(1)) : wr_q;
    assign nmap      = (wc_end && wr_end) ? map_q + MW'(1) : map_q;

    // The first return of a window (phase 1) seeds the running max.
    always_comb begin
        if (state_q == S_READ && ph_q == 2'd1)
            ret_max = rd_data_s;
        else
            ret_max = (rd_data_s > max_q) ? rd_data_s : max_q;
`ifdef CNN_POOL_RELU_EN
        pooled = ret_max[DATA_W_p-1] ? '0 : ret_max;
`else
        pooled = ret_max;
`endif
    end

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        map_d       = map_q;
        wr_d        = wr_q;
        wc_d        = wc_q;
        max_d       = max_q;
        rd_en_d     = rd_en_q;
        rd_map_d    = rd_map_q;
        rd_row_d    = rd_row_q;
        rd_col_d    = rd_col_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_map_d   = out_map_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_READ;
                    ph_d     = 2'd0;
                    map_d    = '0;
                    wr_d     = '0;
                    wc_d     = '0;
                    rd_en_d  = 1'b1;
                    rd_map_d = '0;
                    rd_row_d = '0;
                    rd_col_d = '0;
                    busy_d   = 1'b1;
                end
            end
            S_READ: begin
                if (ph_q != 2'd0)
                    max_d = ret_max;
                if (ph_q == 2'd3) begin
                    state_d = S_FLUSH;
                    rd_en_d = 1'b0;
                end else begin
                    ph_d     = ph_nx;
                    rd_row_d = (wr_q << 1) | RW'(ph_nx[1]);
                    rd_col_d = (wc_q << 1) | CW'(ph_nx[0]);
                end
            end
            S_FLUSH: begin
                state_d     = S_EMIT;
                max_d       = ret_max;
                out_valid_d = 1'b1;
                out_data_d  = pooled;
                out_map_d   = map_q;
                out_last_d  = wc_end && wr_end;
            end
            S_EMIT: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (wc_end && wr_end && map_end) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        map_d   = '0;
                        wr_d    = '0;
                        wc_d    = '0;
                    end else begin
                        state_d  = S_READ;
                        ph_d     = 2'd0;
                        map_d    = nmap;
                        wr_d     = nwr;
                        wc_d     = nwc;
                        rd_en_d  = 1'b1;
                        rd_map_d = nmap;
                        rd_row_d = nwr << 1;
                        rd_col_d = nwc << 1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            ph_q        <= '0;
            map_q       <= '0;
            wr_q        <= '0;
            wc_q        <= '0;
            max_q       <= '0;
            rd_en_q     <= 1'b0;
            rd_map_q    <= '0;
            rd_row_q    <= '0;
            rd_col_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_map_q   <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            map_q       <= map_d;
            wr_q        <= wr_d;
            wc_q        <= wc_d;
            max_q       <= max_d;
            rd_en_q     <= rd_en_d;
            rd_map_q    <= rd_map_d;
            rd_row_q    <= rd_row_d;
            rd_col_q    <= rd_col_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_map_q   <= out_map_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign rd_en_o     = rd_en_q;
    assign rd_map_o    = rd_map_q;
    assign rd_row_o    = rd_row_q;
    assign rd_col_o    = rd_col_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_map_o   = out_map_q;
    assign out_last_o  = out_last_q;

endmodule
